// File: rtl/dmem_responder.sv
// Data-side memory responder for a single-cycle core. It combines a byte-lane RAM with a
// small MMIO window: a cycle counter, a transmit byte FIFO and its status register.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          TX_DEPTH    = 4,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_d_we,
  input  logic [3:0]  mem_d_wmask,
  input  logic [31:0] mem_d_a,
  input  logic [31:0] mem_d_wd,
  output logic [31:0] mem_d_rd,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  logic          mmio_hit;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic [7:0]    lane_rd [4];
  logic [31:0]   ram_rd;

  assign mmio_hit = (mem_d_a[31:4] == MMIO_BASE[31:4]);
  assign reg_sel  = mem_d_a[3:2];
  assign ram_idx  = mem_d_a[AW+1:2];
  assign ram_we   = reset && mem_d_we && !mmio_hit;

  // One RAM per byte lane, so a masked write never needs a read-modify-write.
  // The read is asynchronous: the core expects data in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (ram_we && mem_d_wmask[gi]) begin
          lane_mem[ram_idx] <= mem_d_wd[8*gi +: 8];
        end
      end

      assign lane_rd[gi] = lane_mem[ram_idx];
    end
  endgenerate

  assign ram_rd = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};

  logic [63:0] cycle_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + 64'd1;
    end
  end

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          ovf_set;
  logic          ovf_clr;

  assign fifo_full  = (count_reg == CW'(TX_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign pop        = !fifo_empty && tx_ready;
  assign push_req   = reset && mem_d_we && mmio_hit && (reg_sel == 2'd2) && mem_d_wmask[0];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && !push_ok;
  assign ovf_clr    = reset && mem_d_we && mmio_hit && (reg_sel == 2'd3)
                      && mem_d_wmask[1] && mem_d_wd[10];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= mem_d_wd[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // A new overflow wins over a simultaneous clear.
      overflow_reg <= ovf_set || (overflow_reg && !ovf_clr);
    end
  end

  // Outputs depend only on FIFO state registers, never on the request bus.
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];

  logic [31:0] status_word;

  always_comb begin
    status_word       = '0;
    status_word[7:0]  = 8'(count_reg);
    status_word[8]    = fifo_full;
    status_word[9]    = fifo_empty;
    status_word[10]   = overflow_reg;

    mem_d_rd = ram_rd;
    if (mmio_hit) begin
      case (reg_sel)
        2'd0:    mem_d_rd = cycle_reg[31:0];
        2'd1:    mem_d_rd = cycle_reg[63:32];
        2'd2:    mem_d_rd = 32'h0;
        default: mem_d_rd = status_word;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit data RAM words (power of two).
REQ-002 SHALL have parameter TX_DEPTH, default 4, number of entries in the transmit byte FIFO (power of two, at least 2).
REQ-003 SHALL have parameter MMIO_BASE, default 32'h8000_0000, base of the 16-byte register window.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port mem_d_we  in  1  write request from the core data port.
REQ-007 SHALL have port mem_d_wmask  in  4  byte-lane write enables, bit i = bits [8i+7:8i].
REQ-008 SHALL have port mem_d_a  in  32  byte address; bits [1:0] are ignored.
REQ-009 SHALL have port mem_d_wd  in  32  write data.
REQ-010 SHALL have port mem_d_rd  out  32  read data to the core.
REQ-011 SHALL have port tx_valid  out  1  FIFO head byte is available.
REQ-012 SHALL have port tx_data  out  8  FIFO head byte.
REQ-013 SHALL have port tx_ready  in  1  consumer accepts the head byte.

Function
REQ-014 SHALL decode an MMIO hit when mem_d_a[31:4] == MMIO_BASE[31:4]; every other address SHALL hit RAM.
REQ-015 SHALL index RAM by mem_d_a[log2(DEPTH_WORDS)+1:2], so higher address bits alias.
REQ-016 SHALL drive mem_d_rd combinationally from the current address, with zero-cycle latency, to match the core's single-cycle memory stage.
REQ-017 SHALL, on a RAM write (mem_d_we=1), update only the byte lanes whose wmask bit is set, at the rising edge.
REQ-018 SHALL ignore writes with wmask = 4'b0000.
REQ-019 SHALL return the pre-edge (old) word on a read of an address written in the same cycle.
REQ-020 SHALL keep a 64-bit cycle counter that increments every cycle out of reset and wraps from 2^64-1 to 0.
REQ-021 SHALL implement this MMIO map, byte offsets from MMIO_BASE:
- 0x0 CYCLE_LO: RO, counter[31:0].
- 0x4 CYCLE_HI: RO, counter[63:32], live value.
- 0x8 TXDATA: WO, reads 0.
- 0xC STATUS: [7:0] count, [8] full, [9] empty, [10] overflow, rest 0.
REQ-022 SHALL ignore writes to RO registers.
REQ-023 SHALL push mem_d_wd[7:0] into the FIFO on a write to TXDATA with wmask[0]=1 when the FIFO is not full.
REQ-024 SHALL, on a TXDATA push attempt while full, drop the byte, leave the FIFO unchanged, and set the sticky overflow bit.
REQ-025 SHALL clear overflow on a write to STATUS with wmask[1]=1 and wd[10]=1 (write-1-to-clear); if a clear and a new overflow occur in the same cycle, overflow SHALL end up set.
REQ-026 SHALL drive tx_valid = (count != 0) and tx_data = head entry, both from registers only with no combinational path from mem_d_*.
REQ-027 SHALL pop the FIFO when tx_valid and tx_ready are both 1.
REQ-028 SHALL, on a simultaneous push and pop, accept both and leave count unchanged; when full, the push SHALL be accepted because of the pop.
REQ-029 SHALL make a pushed byte visible on tx_valid/tx_data no earlier than the cycle after the push (no bypass).
REQ-030 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-031 SHALL wrap the read and write pointers modulo TX_DEPTH, and count SHALL never exceed TX_DEPTH.

Reset
REQ-032 SHALL, while reset=0, asynchronously force counter=0, FIFO pointers and count=0, overflow=0, tx_valid=0, and tx_data=0.
REQ-033 SHALL NOT reset RAM contents.
REQ-034 SHALL ignore write requests while reset=0.
REQ-035 SHALL discard FIFO contents when reset is asserted in the middle of a transfer.
REQ-036 SHALL read CYCLE_LO as 0 in the first cycle after reset release and as 1 in the second.

Verification
REQ-037 Byte mask: write 0xAABBCCDD to 0x10 with mask 4'b1111, then 0x11223344 with mask 4'b0101 -> read of 0x10 = 0xAA22CC44.
REQ-038 Alias: with DEPTH_WORDS=1024, write 0x5 to 0x0 -> read of 0x1000 = 0x5; read of 0x0 in the same cycle as the write = old value.
REQ-039 FIFO fill/overflow: tx_ready=0, push 0x41..0x45 -> STATUS = count 4, full 1, overflow 1; tx_data = 0x41.
REQ-040 Drain: then tx_ready=1 -> 0x41, 0x42, 0x43, 0x44 on consecutive cycles, then tx_valid=0, empty=1; W1C of STATUS -> overflow=0.
REQ-041 Full push+pop: FIFO full, tx_ready=1, push 0x50 in the same cycle -> count stays 4 and 0x50 emerges last.
REQ-042 Reset mid-operation: 2 bytes queued and counter=100, pulse reset low mid-cycle -> tx_valid=0 immediately, counter=0, and RAM data is retained.
